// File: rtl/motor_six_step_commutator.sv
// Six-step trapezoidal commutation sequencer driving the 3-phase bridge gate enables.
// Latency: gate outputs are registered and change one clk50 edge after the deciding tick or enable edge.
// Backpressure: none. enI=0 forces all gates off on the next edge, and async reset clears them at once.
//
// Ports:
//   clk50mhzI  system clock, all logic on its rising edge
//   nRstI      asynchronous active-low reset
//   clk1mhzI   1 MHz square wave used as a microsecond timebase (synchronous to clk50mhzI)
//   enI        1 = run the sequencer, 0 = all gates off and hold the step index
//   dirI       1 = forward (step+1), 0 = reverse (step-1), sampled at the advancing tick
//   periodI    drive time per step in ticks, latched when DEAD hands over to DRIVE
//   gateO      {AH,AL,BH,BL,CH,CL}, 1 = transistor on
//   stepIdxO   current commutation step, 0..5
//   stepPulseO one-cycle pulse whenever the step index changes
//   busyO      1 whenever the sequencer is not idle
module motor_six_step_commutator #(
  parameter int PERIOD_W   = 16,
  parameter int DEAD_TICKS = 2,
  parameter int MIN_PERIOD = 4
) (
  input  logic                clk50mhzI,
  input  logic                nRstI,
  input  logic                clk1mhzI,
  input  logic                enI,
  input  logic                dirI,
  input  logic [PERIOD_W-1:0] periodI,
  output logic [5:0]          gateO,
  output logic [2:0]          stepIdxO,
  output logic                stepPulseO,
  output logic                busyO
);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

  // With DEAD_TICKS=0 this constant is never compared, so its wrapped value does not matter.
  localparam logic [PERIOD_W-1:0] DEAD_LAST = PERIOD_W'(DEAD_TICKS - 1);
  localparam logic [PERIOD_W-1:0] MIN_PER   = PERIOD_W'(MIN_PERIOD);

  // Only one of the high/low pair of each phase is ever set in the table below.
  function automatic logic [5:0] gatePattern(input logic [2:0] idx);
    case (idx)
      3'd0:    gatePattern = 6'b100100;
      3'd1:    gatePattern = 6'b100001;
      3'd2:    gatePattern = 6'b001001;
      3'd3:    gatePattern = 6'b011000;
      3'd4:    gatePattern = 6'b010010;
      3'd5:    gatePattern = 6'b000110;
      default: gatePattern = 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] nextIdx(input logic [2:0] idx, input logic fwd);
    if (fwd) nextIdx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    else     nextIdx = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  endfunction

  state_t              state, stateNxt;
  logic [PERIOD_W-1:0] cnt, cntNxt;
  logic [PERIOD_W-1:0] perLat, perLatNxt;
  logic [2:0]          stepIdx, stepIdxNxt;
  logic [5:0]          gate, gateNxt;
  logic                stepPulse, stepPulseNxt;
  logic                clk1Prev;
  logic                tick;
  logic [PERIOD_W-1:0] perClamped;
  logic [2:0]          advIdx;

  // Rising edge of the 1 MHz timebase, one clk50 cycle wide.
  assign tick       = clk1mhzI & ~clk1Prev;
  assign perClamped = (periodI < MIN_PER) ? MIN_PER : periodI;
  assign advIdx     = nextIdx(stepIdx, dirI);

  // State register.
  always_ff @(posedge clk50mhzI or negedge nRstI) begin
    if (!nRstI) begin
      state     <= IDLE;
      cnt       <= '0;
      perLat    <= MIN_PER;
      stepIdx   <= 3'd0;
      gate      <= 6'b0;
      stepPulse <= 1'b0;
      clk1Prev  <= 1'b0;
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      perLat    <= perLatNxt;
      stepIdx   <= stepIdxNxt;
      gate      <= gateNxt;
      stepPulse <= stepPulseNxt;
      clk1Prev  <= clk1mhzI;
    end
  end

  // Next-state logic. Disable has priority over everything, including a step advance
  // landing in the same cycle, so the step index is simply held.
  always_comb begin
    stateNxt     = state;
    cntNxt       = cnt;
    perLatNxt    = perLat;
    stepIdxNxt   = stepIdx;
    gateNxt      = gate;
    stepPulseNxt = 1'b0;
    if (!enI) begin
      stateNxt = IDLE;
      cntNxt   = '0;
      gateNxt  = 6'b0;
    end else begin
      case (state)
        IDLE: begin
          cntNxt = '0;
          if (DEAD_TICKS == 0) begin
            stateNxt  = DRIVE;
            gateNxt   = gatePattern(stepIdx);
            perLatNxt = perClamped;
          end else begin
            stateNxt = DEAD;
            gateNxt  = 6'b0;
          end
        end
        DEAD: begin
          if (tick) begin
            if (cnt == DEAD_LAST) begin
              stateNxt  = DRIVE;
              gateNxt   = gatePattern(stepIdx);
              perLatNxt = perClamped;
              cntNxt    = '0;
            end else begin
              cntNxt = cnt + 1'b1;
            end
          end
        end
        DRIVE: begin
          if (tick) begin
            if (cnt == perLat - 1'b1) begin
              stepIdxNxt   = advIdx;
              stepPulseNxt = 1'b1;
              cntNxt       = '0;
              if (DEAD_TICKS == 0) begin
                gateNxt   = gatePattern(advIdx);
                perLatNxt = perClamped;
              end else begin
                stateNxt = DEAD;
                gateNxt  = 6'b0;
              end
            end else begin
              cntNxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          stateNxt = IDLE;
          cntNxt   = '0;
          gateNxt  = 6'b0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    gateO      = gate;
    stepIdxO   = stepIdx;
    stepPulseO = stepPulse;
    busyO      = (state != IDLE);
  end

endmodule

// File: tb/tb_motor_six_step_commutator.sv
// Bench for motor_six_step_commutator: directed vector table, hand sequences for
// disable/resume and async reset, then randomized inputs under a continuous monitor.
// The 1 MHz timebase is compressed to one tick every TCK clk50 cycles.
module tb_motor_six_step_commutator;

  localparam int PW    = 16;
  localparam int TCK   = 4;
  localparam int DEADT = 2;
  localparam int MINP  = 4;

  logic          clk50 = 1'b0;
  logic          clk1  = 1'b0;
  logic          nRst  = 1'b0;
  logic          en    = 1'b0;
  logic          dir   = 1'b1;
  logic [PW-1:0] period = 16'd10;
  logic [5:0]    gate;
  logic [2:0]    idx;
  logic          pulse;
  logic          busy;

  int nChecks = 0;
  int nFails  = 0;

  motor_six_step_commutator #(.PERIOD_W(PW), .DEAD_TICKS(DEADT), .MIN_PERIOD(MINP)) dut (
    .clk50mhzI (clk50),
    .nRstI     (nRst),
    .clk1mhzI  (clk1),
    .enI       (en),
    .dirI      (dir),
    .periodI   (period),
    .gateO     (gate),
    .stepIdxO  (idx),
    .stepPulseO(pulse),
    .busyO     (busy)
  );

  // clk50 rises at 10+20k; clk1 toggles on clk50 falling edges, so ticks land cleanly.
  always #10 clk50 = ~clk50;
  always #(10 * TCK) clk1 = ~clk1;

  logic [5:0] PAT [8] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000,
                          6'b010010, 6'b000110, 6'b000000, 6'b000000};

  function automatic int advance(input int i, input logic d);
    return d ? (i + 1) % 6 : (i + 5) % 6;
  endfunction

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- continuous monitor (samples on falling clk50) ----------------
  bit         monOn = 1'b0;
  int         cyc = 0;
  int         pulses = 0;
  logic [5:0] pGate = 6'b0;
  int         pIdx = 0;
  bit         riseOk = 1'b0;
  bit         patOk = 1'b0;
  int         riseCyc = 0;
  int         fallCyc = 0;
  int         expLen = 0;
  logic [5:0] lastPat = 6'b0;

  always @(negedge clk50) begin
    cyc++;
    if (monOn) begin
      chk("shoot_through", !((gate[5] & gate[4]) | (gate[3] & gate[2]) | (gate[1] & gate[0])),
          int'(gate), 0);
      if (gate != '0) begin
        chk("gate_vs_table", gate == PAT[idx], int'(gate), int'(PAT[idx]));
        chk("busy_while_drive", busy == 1'b1, int'(busy), 1);
      end
      if (!en) begin
        chk("disable_gate", gate == '0, int'(gate), 0);
        chk("disable_busy", busy == 1'b0, int'(busy), 0);
        chk("disable_hold_idx", int'(idx) == pIdx, int'(idx), pIdx);
      end
      chk("pulse_vs_idx_change", pulse == (int'(idx) != pIdx), int'(pulse), int'(int'(idx) != pIdx));
      if (int'(idx) != pIdx)
        chk("step_direction", int'(idx) == advance(pIdx, dir), int'(idx), advance(pIdx, dir));
      if (pulse) begin
        pulses++;
        chk("pulse_at_drive_end", pGate != '0 && gate == '0, int'(gate), 0);
      end
      if (pGate == '0 && gate != '0) begin
        if (patOk && gate != lastPat)
          chk("dead_gap", cyc - fallCyc >= DEADT * TCK, cyc - fallCyc, DEADT * TCK);
        riseOk  = 1'b1;
        riseCyc = cyc;
        expLen  = ((int'(period) < MINP) ? MINP : int'(period)) * TCK;
      end
      if (pGate != '0 && gate == '0) begin
        if (riseOk && pulse)
          chk("drive_length", cyc - riseCyc == expLen, cyc - riseCyc, expLen);
        riseOk  = 1'b0;
        fallCyc = cyc;
        lastPat = pGate;
        patOk   = 1'b1;
      end
    end else begin
      riseOk = 1'b0;
      patOk  = 1'b0;
    end
    pGate = gate;
    pIdx  = int'(idx);
  end

  // Waits on falling edges until gate is (non)zero; n = samples taken including the hit.
  task automatic waitGate(input bit nonzero, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk50);
      n++;
    end while (((gate != '0) != nonzero) && n < limit);
    if ((gate != '0) != nonzero) chk("wait_timeout", 1'b0, n, limit);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          dir;      // direction in force for the advance into this step
    logic [PW-1:0] period;   // periodI when this step's drive starts
    int            expIdx;
    logic [5:0]    expGate;
    int            expTicks; // drive time in ticks after clamping
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    int n;
    int p0;

    vecs[0]  = '{1'b1, 16'd10, 0, 6'b100100, 10};
    vecs[1]  = '{1'b1, 16'd10, 1, 6'b100001, 10};
    vecs[2]  = '{1'b1, 16'd10, 2, 6'b001001, 10};
    vecs[3]  = '{1'b1, 16'd10, 3, 6'b011000, 10};
    vecs[4]  = '{1'b1, 16'd10, 4, 6'b010010, 10};
    vecs[5]  = '{1'b1, 16'd10, 5, 6'b000110, 10};
    vecs[6]  = '{1'b1, 16'd10, 0, 6'b100100, 10};
    vecs[7]  = '{1'b0, 16'd1,  5, 6'b000110, 4};
    vecs[8]  = '{1'b0, 16'd0,  4, 6'b010010, 4};
    vecs[9]  = '{1'b1, 16'd5,  5, 6'b000110, 5};
    vecs[10] = '{1'b1, 16'd4,  0, 6'b100100, 4};
    vecs[11] = '{1'b1, 16'd4,  1, 6'b100001, 4};
    vecs[12] = '{1'b1, 16'd3,  2, 6'b001001, 4};

    // Reset state.
    repeat (3) @(negedge clk50);
    #1;
    chk("reset_gate", gate == '0, int'(gate), 0);
    chk("reset_idx", idx == 3'd0, int'(idx), 0);
    chk("reset_busy", busy == 1'b0, int'(busy), 0);
    chk("reset_pulse", pulse == 1'b0, int'(pulse), 0);
    nRst = 1'b1;
    @(negedge clk50);
    #1;
    chk("idle_busy", busy == 1'b0, int'(busy), 0);
    monOn = 1'b1;

    // Table run: forward sequence with wrap, reverse wrap, clamped periods.
    dir    = vecs[0].dir;
    period = vecs[0].period;
    en     = 1'b1;
    for (int i = 0; i < NV; i++) begin
      waitGate(1'b1, 400, n);
      if (i > 0) chk("vec_dead_len", n == DEADT * TCK, n, DEADT * TCK);
      chk("vec_gate", gate == vecs[i].expGate, int'(gate), int'(vecs[i].expGate));
      chk("vec_idx", int'(idx) == vecs[i].expIdx, int'(idx), vecs[i].expIdx);
      if (i + 1 < NV) begin
        dir    = vecs[i + 1].dir;
        period = vecs[i + 1].period;
      end
      waitGate(1'b0, 400, n);
      chk("vec_drive_len", n == vecs[i].expTicks * TCK, n, vecs[i].expTicks * TCK);
      chk("vec_pulse", pulse == 1'b1, int'(pulse), 1);
    end

    // Disable mid-drive at step 3, then resume the same step.
    period = 16'd10;
    waitGate(1'b1, 400, n);
    chk("step3_gate", gate == 6'b011000, int'(gate), int'(6'b011000));
    repeat (5) @(negedge clk50);
    #1;
    en = 1'b0;
    @(negedge clk50);
    #1;
    chk("dis_next_gate", gate == '0, int'(gate), 0);
    chk("dis_next_busy", busy == 1'b0, int'(busy), 0);
    chk("dis_next_idx", idx == 3'd3, int'(idx), 3);
    repeat (20) @(negedge clk50);
    #1;
    chk("dis_held_idx", idx == 3'd3, int'(idx), 3);
    en = 1'b1;
    waitGate(1'b1, 100, n);
    chk("resume_dead", (n - 1) >= TCK + 1 && (n - 1) <= DEADT * TCK, n - 1, DEADT * TCK);
    chk("resume_gate", gate == 6'b011000, int'(gate), int'(6'b011000));
    chk("resume_idx", idx == 3'd3, int'(idx), 3);

    // Asynchronous reset in the middle of a drive phase.
    repeat (7) @(negedge clk50);
    #1;
    chk("pre_reset_drive", gate == 6'b011000, int'(gate), int'(6'b011000));
    monOn = 1'b0;
    #3;
    nRst = 1'b0;
    #1;
    chk("async_reset_gate", gate == '0, int'(gate), 0);
    chk("async_reset_idx", idx == 3'd0, int'(idx), 0);
    chk("async_reset_busy", busy == 1'b0, int'(busy), 0);
    repeat (3) @(negedge clk50);
    #1;
    nRst = 1'b1;
    monOn = 1'b1;

    // Randomized run; disables are held long enough to cover a full dead-time.
    p0 = pulses;
    begin
      int lowLeft;
      lowLeft = 0;
      en = 1'b1;
      for (int c = 0; c < 40000; c++) begin
        @(negedge clk50);
        #1;
        if (lowLeft > 0) begin
          lowLeft--;
          if (lowLeft == 0) en = 1'b1;
        end else if ($urandom_range(0, 599) == 0) begin
          en = 1'b0;
          lowLeft = $urandom_range(2 * TCK, 10 * TCK);
        end
        if ($urandom_range(0, 63) == 0) dir = ~dir;
        if ($urandom_range(0, 39) == 0) period = 16'($urandom_range(0, 12));
      end
    end
    chk("random_activity", pulses - p0 > 100, pulses - p0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
